lcd_read_ctrl: RTL and testbench



---
 rtl/lcd_pkg.sv | 23 ++
 rtl/lcd_read_ctrl_if.sv | 30 +++
 rtl/lcd_phase_timer.sv | 25 ++
 rtl/lcd_read_ctrl.sv | 165 ++++++++++++++++
 tb/tb_lcd_read_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 read-side controller.
// States, RS encodings, default bus timing and busy-flag position.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EHIGH,
    ELOW,
    DONE
  } state_t;

  localparam logic LCD_RS_CMD  = 1'b0;
  localparam logic LCD_RS_DATA = 1'b1;

  localparam int T_AS_DEF     = 3;
  localparam int T_EH_DEF     = 13;
  localparam int T_EL_DEF     = 13;
  localparam int POLL_MAX_DEF = 255;

  localparam int BF_BIT = 7;

endpackage

// File: rtl/lcd_read_ctrl_if.sv
// Request/response and LCD pin bundle for the read controller.
// master = requester/board side, slave = lcd_read_ctrl.
interface lcd_read_ctrl_if;

  logic       cmd_valid;
  logic       cmd_rs;
  logic       cmd_poll;
  logic       cmd_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_timeout;
  logic [7:0] lcd_db_in;
  logic       lcd_RS;
  logic       lcd_RW;
  logic       lcd_E;
  logic       bus_busy;

  modport master (
    output cmd_valid, cmd_rs, cmd_poll, lcd_db_in,
    input  cmd_ready, rsp_valid, rsp_data, rsp_timeout,
    input  lcd_RS, lcd_RW, lcd_E, bus_busy
  );

  modport slave (
    input  cmd_valid, cmd_rs, cmd_poll, lcd_db_in,
    output cmd_ready, rsp_valid, rsp_data, rsp_timeout,
    output lcd_RS, lcd_RW, lcd_E, bus_busy
  );

endinterface

// File: rtl/lcd_phase_timer.sv
// 8-bit loadable down-counter timing one bus phase.
// A load of 0 behaves as 1; done is high on the last cycle of a phase.
module lcd_phase_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       done
);

  // reload on request, otherwise count down and park at 1
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= 8'd0;
    end else if (load) begin
      value <= (load_val == 8'd0) ? 8'd1 : load_val;
    end else if (value > 8'd1) begin
      value <= value - 8'd1;
    end
  end

  assign done = (value <= 8'd1);

endmodule

// File: rtl/lcd_read_ctrl.sv
// Single-cycle-read controller for an HD44780 LCD (BF/AC or RAM data).
// Optional busy-flag polling is built when LCD_BUSY_POLL_EN is defined.
module lcd_read_ctrl
  import lcd_pkg::*;
#(
  parameter int T_AS_CYC = T_AS_DEF,
  parameter int T_EH_CYC = T_EH_DEF,
  parameter int T_EL_CYC = T_EL_DEF,
  parameter int POLL_MAX = POLL_MAX_DEF
) (
  input logic           clk,
  input logic           rst,
  lcd_read_ctrl_if.slave bus
);

  localparam logic [7:0] AS = 8'(T_AS_CYC);
  localparam logic [7:0] EH = 8'(T_EH_CYC);
  localparam logic [7:0] EL = 8'(T_EL_CYC);

  if (T_AS_CYC > 255 || T_EH_CYC > 255 ||
      T_EL_CYC > 255 || POLL_MAX > 255) begin : g_range_err
    $error("lcd_read_ctrl: timing/poll parameter above 255");
  end

  state_t     state;
  state_t     state_n;
  logic       rs_q;
  logic [7:0] cap_q;
  logic [7:0] rsp_q;
  logic       to_q;
  logic       tmr_load;
  logic [7:0] tmr_val;
  logic [7:0] tmr_value;
  logic       tmr_done;
  logic       accept;
  logic       cap_en;
  logic       rsp_en;
  logic       again;
  logic       to_n;
  logic       active;

  lcd_phase_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .done     (tmr_done)
  );

  assign accept = (state == IDLE) && bus.cmd_valid && !rst;
  assign cap_en = (state == EHIGH) && (tmr_value == 8'd1);

`ifdef LCD_BUSY_POLL_EN
  localparam logic [7:0] PM = 8'(POLL_MAX);

  logic       poll_q;
  logic [7:0] reads_q;
  logic       bf_set;

  // per-request poll mode and count of completed reads
  always_ff @(posedge clk) begin
    if (rst) begin
      poll_q  <= 1'b0;
      reads_q <= 8'd0;
    end else if (accept) begin
      poll_q  <= bus.cmd_poll && (bus.cmd_rs == LCD_RS_CMD);
      reads_q <= 8'd0;
    end else if (cap_en) begin
      reads_q <= reads_q + 8'd1;
    end
  end

  assign bf_set = poll_q && cap_q[BF_BIT];
  assign again  = bf_set && (reads_q < PM);
  assign to_n   = bf_set && !again;
`else
  assign again = 1'b0;
  assign to_n  = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // request latch, bus capture and held response
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_q  <= LCD_RS_CMD;
      cap_q <= 8'h00;
      rsp_q <= 8'h00;
      to_q  <= 1'b0;
    end else begin
      if (accept) rs_q <= bus.cmd_rs;
      if (cap_en) cap_q <= bus.lcd_db_in;
      if (rsp_en) begin
        rsp_q <= cap_q;
        to_q  <= to_n;
      end
    end
  end

  // next state and phase timer loads
  always_comb begin
    state_n  = state;
    tmr_load = 1'b0;
    tmr_val  = AS;
    rsp_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_n  = SETUP;
          tmr_load = 1'b1;
          tmr_val  = AS;
        end
      end
      SETUP: begin
        if (tmr_done) begin
          state_n  = EHIGH;
          tmr_load = 1'b1;
          tmr_val  = EH;
        end
      end
      EHIGH: begin
        if (tmr_done) begin
          state_n  = ELOW;
          tmr_load = 1'b1;
          tmr_val  = EL;
        end
      end
      ELOW: begin
        if (tmr_done) begin
          if (again) begin
            state_n  = SETUP;
            tmr_load = 1'b1;
            tmr_val  = AS;
          end else begin
            state_n = DONE;
            rsp_en  = 1'b1;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign active = (state == SETUP) || (state == EHIGH) ||
                  (state == ELOW);

  assign bus.cmd_ready   = (state == IDLE) && !rst;
  assign bus.lcd_RW      = active;
  assign bus.bus_busy    = active;
  assign bus.lcd_RS      = active && rs_q;
  assign bus.lcd_E       = (state == EHIGH);
  assign bus.rsp_valid   = (state == DONE);
  assign bus.rsp_data    = rsp_q;
  assign bus.rsp_timeout = (state == DONE) && to_q;

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// Directed bench for lcd_read_ctrl with hand-computed timing and data.
// Poll cases are built when LCD_BUSY_POLL_EN is defined.
module tb_lcd_read_ctrl;
  import lcd_pkg::*;

`ifdef LCD_BUSY_POLL_EN
  localparam int PM = 4;
`else
  localparam int PM = 255;
`endif

  localparam int LAT1 = 30;
  localparam int LAT4 = 117;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  lcd_read_ctrl_if bus ();

  lcd_read_ctrl #(
    .T_AS_CYC (3),
    .T_EH_CYC (13),
    .T_EL_CYC (13),
    .POLL_MAX (PM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int       m_lat;
  int       m_pulses;
  int       m_ehigh;
  int       m_setup;
  int       m_acc;
  logic [7:0] m_data;
  logic     m_to;
  logic     m_ready_req;
  logic     m_ready_bad;
  logic     m_rw_bad;
  logic     m_end_bad;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // issue one request from a negedge and watch it until rsp_valid
  task automatic txn(input logic rs, input logic poll,
                     input logic [7:0] db_a, input logic [7:0] db_b,
                     input int sw_after, input logic hold);
    int   k;
    int   first_e;
    logic prev_e;
    m_lat = 0; m_pulses = 0; m_ehigh = 0; m_setup = 0;
    m_data = 8'h00; m_to = 1'b0;
    m_ready_bad = 1'b0; m_rw_bad = 1'b0; m_end_bad = 1'b0;
    bus.cmd_rs    = rs;
    bus.cmd_poll  = poll;
    bus.lcd_db_in = db_a;
    bus.cmd_valid = 1'b1;
    m_ready_req   = bus.cmd_ready;
    @(posedge clk);
    @(negedge clk);
    m_acc = cyc;
    bus.cmd_valid = hold;
    prev_e = 1'b0;
    first_e = 0;
    k = 0;
    while (k < 400 && m_lat == 0) begin
      k++;
      if (bus.cmd_ready) m_ready_bad = 1'b1;
      if (bus.rsp_valid) begin
        m_lat  = k;
        m_data = bus.rsp_data;
        m_to   = bus.rsp_timeout;
        if (bus.lcd_RW || bus.bus_busy || bus.lcd_E) m_end_bad = 1'b1;
      end else begin
        if (!bus.lcd_RW || !bus.bus_busy || bus.lcd_RS !== rs)
          m_rw_bad = 1'b1;
        if (bus.lcd_E) begin
          m_ehigh++;
          if (!prev_e) m_pulses++;
          if (first_e == 0) first_e = k;
        end else begin
          if (first_e == 0) m_setup++;
          if (prev_e && m_pulses == sw_after) bus.lcd_db_in = db_b;
        end
        prev_e = bus.lcd_E;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int acc0;
    int nrsp;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_rs = 1'b0;
    bus.cmd_poll = 1'b0;
    bus.lcd_db_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.cmd_ready, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_data", bus.rsp_data, 8'h00);
    check("rst_timeout", bus.rsp_timeout, 1'b0);
    check("rst_rs", bus.lcd_RS, 1'b0);
    check("rst_rw", bus.lcd_RW, 1'b0);
    check("rst_e", bus.lcd_E, 1'b0);
    check("rst_busy", bus.bus_busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", bus.cmd_ready, 1'b1);

    txn(LCD_RS_CMD, 1'b0, 8'h25, 8'h25, 0, 1'b0);
    check("t1_ready_req", m_ready_req, 1'b1);
    check("t1_lat", m_lat, LAT1);
    check("t1_pulses", m_pulses, 1);
    check("t1_ehigh", m_ehigh, 13);
    check("t1_setup", m_setup, 3);
    check("t1_data", m_data, 8'h25);
    check("t1_timeout", m_to, 1'b0);
    check("t1_ready_busy", m_ready_bad, 1'b0);
    check("t1_rw_active", m_rw_bad, 1'b0);
    check("t1_rw_done", m_end_bad, 1'b0);
    @(negedge clk);
    check("t1_pulse_len", bus.rsp_valid, 1'b0);
    check("t1_hold", bus.rsp_data, 8'h25);
    check("t1_rw_idle", bus.lcd_RW, 1'b0);

    txn(LCD_RS_DATA, 1'b0, 8'h41, 8'hFF, 1, 1'b0);
    check("t2_lat", m_lat, LAT1);
    check("t2_data", m_data, 8'h41);
    check("t2_rs", m_rw_bad, 1'b0);
    @(negedge clk);

    txn(LCD_RS_CMD, 1'b0, 8'h11, 8'h11, 0, 1'b1);
    acc0 = m_acc;
    check("t3_lat", m_lat, LAT1);
    check("t3_data", m_data, 8'h11);
    check("t3_ready_busy", m_ready_bad, 1'b0);
    @(negedge clk);
    check("t3_ready_after", bus.cmd_ready, 1'b1);
    txn(LCD_RS_CMD, 1'b0, 8'h22, 8'h22, 0, 1'b0);
    check("t3_spacing", m_acc - acc0, 31);
    check("t3b_data", m_data, 8'h22);
    check("t3b_ready_busy", m_ready_bad, 1'b0);
    @(negedge clk);

    bus.cmd_rs = LCD_RS_DATA;
    bus.cmd_poll = 1'b0;
    bus.lcd_db_in = 8'h33;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("t4_e_before", bus.lcd_E, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t4_e_after", bus.lcd_E, 1'b0);
    check("t4_rw_after", bus.lcd_RW, 1'b0);
    check("t4_busy_after", bus.bus_busy, 1'b0);
    check("t4_data_clr", bus.rsp_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    nrsp = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) nrsp++;
    end
    check("t4_no_rsp", nrsp, 0);
    txn(LCD_RS_DATA, 1'b0, 8'h5A, 8'h5A, 0, 1'b0);
    check("t4_next_lat", m_lat, LAT1);
    check("t4_next_data", m_data, 8'h5A);
    @(negedge clk);

`ifdef LCD_BUSY_POLL_EN
    txn(LCD_RS_CMD, 1'b1, 8'h80, 8'h07, 3, 1'b0);
    check("p1_pulses", m_pulses, 4);
    check("p1_lat", m_lat, LAT4);
    check("p1_data", m_data, 8'h07);
    check("p1_timeout", m_to, 1'b0);
    check("p1_busy", m_rw_bad, 1'b0);
    @(negedge clk);
    txn(LCD_RS_CMD, 1'b1, 8'h80, 8'h80, 99, 1'b0);
    check("p2_pulses", m_pulses, 4);
    check("p2_lat", m_lat, LAT4);
    check("p2_data", m_data, 8'h80);
    check("p2_timeout", m_to, 1'b1);
    @(negedge clk);
    check("p2_to_pulse", bus.rsp_timeout, 1'b0);
    txn(LCD_RS_DATA, 1'b1, 8'h80, 8'h80, 99, 1'b0);
    check("p3_pulses", m_pulses, 1);
    check("p3_timeout", m_to, 1'b0);
`else
    txn(LCD_RS_CMD, 1'b1, 8'h80, 8'h80, 99, 1'b0);
    check("np_pulses", m_pulses, 1);
    check("np_lat", m_lat, LAT1);
    check("np_data", m_data, 8'h80);
    check("np_timeout", m_to, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
